// File: rtl/bit_diff_engine_pkg.sv
// bit_diff_engine_pkg: shared FSM state type and result-width helper
package bit_diff_engine_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, PUSH} state_t;
  function automatic int rw_width(input int width);
    return $clog2(2 * width + 1);
  endfunction
endpackage

// File: rtl/bit_diff_engine_if.sv
// bit_diff_engine_if: input stream, result stream and status signals of the engine
interface bit_diff_engine_if
  import bit_diff_engine_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int COUNT_WIDTH = 32
);
  localparam int RW = rw_width(WIDTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [RW-1:0]   out_result;
  logic [LW-1:0]          fifo_level;
  logic [COUNT_WIDTH-1:0] count;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_result, fifo_level, count
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_result, fifo_level, count
  );
endinterface

// File: rtl/bit_diff_fifo.sv
// bit_diff_fifo: first-word-fall-through FIFO with occupancy output
module bit_diff_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;
  assign valid = level != '0;
  assign rd    = pop && valid;
  assign wr    = push && (level != LW'(DEPTH) || rd);
  assign dout  = valid ? mem[rd_ptr] : '0;
  // pointers wrap naturally at DEPTH; level tracks pushes minus pops
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      level  <= level + LW'(wr) - LW'(rd);
    end
  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/bit_diff_engine.sv
// bit_diff_engine: ones-minus-zeros per word, queued in a FWFT FIFO; BIT_DIFF_ENGINE_STATS_EN builds the result counter
module bit_diff_engine
  import bit_diff_engine_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int COUNT_WIDTH    = 32
) (
  input logic              clk,
  input logic              rst,
  bit_diff_engine_if.slave bus
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int RW = rw_width(WIDTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = N > 1 ? $clog2(N) : 1;
  state_t               state, state_nxt;
  logic [WIDTH-1:0]     data;
  logic signed [RW-1:0] diff, diff_nxt;
  logic [BW-1:0]        beat;
  logic                 accept, last, push;
  assign bus.in_ready = state == IDLE && bus.fifo_level < LW'(FIFO_DEPTH);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last         = beat == BW'(N - 1);
  assign push         = state == PUSH;
  // one word in flight: accept, N compute beats, one push cycle
  always_comb begin
    state_nxt = state == IDLE    ? (accept ? COMPUTE : IDLE) :
                state == COMPUTE ? (last ? PUSH : COMPUTE) : IDLE;
  end
  // each set bit of the chunk adds +1, each clear bit -1
  always_comb begin
    diff_nxt = diff - RW'(BITS_PER_CYCLE);
    for (int i = 0; i < BITS_PER_CYCLE; i++) diff_nxt = diff_nxt + (data[i] ? RW'(2) : RW'(0));
  end
  // latch the word on accept, then consume it LSB chunk first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      diff  <= '0;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data <= bus.in_data;
        diff <= '0;
        beat <= '0;
      end else if (state == COMPUTE) begin
        data <= data >> BITS_PER_CYCLE;
        diff <= diff_nxt;
        beat <= beat + BW'(1);
      end
    end
  bit_diff_fifo #(.DW(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.out_ready),
    .din   (diff),
    .dout  (bus.out_result),
    .valid (bus.out_valid),
    .level (bus.fifo_level)
  );
`ifdef BIT_DIFF_ENGINE_STATS_EN
  logic [COUNT_WIDTH-1:0] cnt;
  // every push lands in the FIFO, so pushes are the completed results
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (push) cnt <= cnt + COUNT_WIDTH'(1);
  assign bus.count = cnt;
`else
  assign bus.count = COUNT_WIDTH'(0);
`endif
endmodule

// File: tb/tb_bit_diff_engine.sv
// tb_bit_diff_engine: random and directed checks of bit_diff_engine against a word-level model
module tb_bit_diff_engine;
  localparam int W = 32;
  localparam int B = 4;
  localparam int D = 16;
  localparam int N = W / B;
  logic clk = 0;
  logic rst = 1;
  int n_tests = 0;
  int n_fail = 0;
  int n_pushed = 0;
  int exp_q[$];
  logic       f_push = 0, f_pop = 0, f_valid;
  logic [7:0] f_din = 0, f_dout;
  logic [4:0] f_level;
  always #5 clk = ~clk;
  bit_diff_engine_if #(.WIDTH(W), .FIFO_DEPTH(D), .COUNT_WIDTH(32)) bus ();
  bit_diff_engine #(.WIDTH(W), .BITS_PER_CYCLE(B), .FIFO_DEPTH(D), .COUNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  bit_diff_fifo #(.DW(8), .DEPTH(D)) u_fifo_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .pop   (f_pop),
    .din   (f_din),
    .dout  (f_dout),
    .valid (f_valid),
    .level (f_level)
  );
  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int ref_diff(input logic [W-1:0] w);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(w[i]);
    return ones - (W - ones);
  endfunction
  function automatic longint exp_count();
`ifdef BIT_DIFF_ENGINE_STATS_EN
    return n_pushed;
`else
    return 0;
`endif
  endfunction
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
      else check("result", $signed(bus.out_result), exp_q.pop_front());
    end
  task automatic send(input logic [W-1:0] w);
    int t = 0;
    bus.in_valid = 1;
    bus.in_data  = w;
    @(negedge clk);
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.in_data  = $urandom;
    exp_q.push_back(ref_diff(w));
    n_pushed++;
  endtask
  task automatic wait_level(input int v);
    int t = 0;
    while (int'(bus.fifo_level) != v && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("level_wait", bus.fifo_level, v);
  endtask
  task automatic drain();
    int t = 0;
    bus.out_ready = 1;
    while ((exp_q.size() != 0 || bus.fifo_level != 0) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    check("count", bus.count, exp_count());
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    exp_q.delete();
    n_pushed = 0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_count", bus.count, 0);
    check("rst_out_result", bus.out_result, 0);
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    bus.in_valid  = 0;
    bus.in_data   = 0;
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    do_reset();
    send(32'hFFFF_FFFF);
    for (k = 1; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) break;
    end
    check("latency", k + 1, N + 2);
    check("lat_result", $signed(bus.out_result), 32);
    check("lat_count", bus.count, exp_count());
    drain();
    send(32'h0000_0000);
    send(32'h0000_FFFF);
    send(32'h0000_0001);
    drain();
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      send(i % 3 == 0 ? $urandom & $urandom : $urandom);
    end
    drain();
    bus.out_ready = 0;
    for (int i = 0; i < D; i++) send($urandom);
    wait_level(D);
    check("full_in_ready", bus.in_ready, 0);
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    bus.out_ready = 0;
    check("pop_level", bus.fifo_level, D - 1);
    check("pop_in_ready", bus.in_ready, 1);
    drain();
    for (int i = 0; i < D; i++) begin
      f_push = 1;
      f_din  = 8'(i);
      @(posedge clk);
      #1;
    end
    f_push = 0;
    check("ff_full_level", f_level, D);
    f_push = 1;
    f_pop  = 1;
    f_din  = 8'd100;
    @(negedge clk);
    check("ff_head_before", f_dout, 0);
    @(posedge clk);
    #1;
    f_push = 0;
    check("ff_level_pp", f_level, D);
    check("ff_head_after", f_dout, 1);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      check("ff_drain", f_dout, i < D - 1 ? i + 1 : 100);
      @(posedge clk);
      #1;
    end
    f_pop = 0;
    check("ff_empty", f_level, 0);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) send($urandom);
    wait_level(3);
    send(32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    do_reset();
    bus.out_ready = 1;
    send(32'hFFFF_FFFF);
    check("post_rst_head", exp_q[0], 32);
    drain();
    for (int i = 0; i < 5; i++) send($urandom);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
